// File: rtl/sp_bram_arb2.sv
// sp_bram_arb2: two-requester arbiter in front of a single-port no-change block RAM
module sp_bram_arb2 #(
    parameter int G_ADDR  = 6,
    parameter int G_WIDTH = 16,
    parameter bit G_RR    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_a,
    input  logic               we_a,
    input  logic [G_ADDR-1:0]  addr_a,
    input  logic [G_WIDTH-1:0] wdata_a,
    output logic               gnt_a,
    output logic               rvalid_a,
    output logic [G_WIDTH-1:0] rdata_a,
    input  logic               req_b,
    input  logic               we_b,
    input  logic [G_ADDR-1:0]  addr_b,
    input  logic [G_WIDTH-1:0] wdata_b,
    output logic               gnt_b,
    output logic               rvalid_b,
    output logic [G_WIDTH-1:0] rdata_b,
    output logic               mem_we,
    output logic [G_ADDR-1:0]  mem_addr,
    output logic [G_WIDTH-1:0] mem_din,
    input  logic [G_WIDTH-1:0] mem_dout
);
    logic last_b;
    // A takes contention under fixed priority or when B was served last; granted port drives the RAM
    always_comb begin
        gnt_a    = rst_n && req_a && (!req_b || !G_RR || last_b);
        gnt_b    = rst_n && req_b && !gnt_a;
        mem_we   = gnt_a ? we_a : gnt_b ? we_b : 1'b0;
        mem_addr = gnt_a ? addr_a : gnt_b ? addr_b : '0;
        mem_din  = gnt_a ? wdata_a : gnt_b ? wdata_b : '0;
    end
    // remember the last winner and tag accepted reads for the cycle their data appears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b   <= 1'b1;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            if (gnt_a || gnt_b) last_b <= gnt_b;
            rvalid_a <= gnt_a && !we_a;
            rvalid_b <= gnt_b && !we_b;
        end
    end
    assign rdata_a = mem_dout;
    assign rdata_b = mem_dout;
endmodule

// File: tb/tb_sp_bram_arb2.sv
// tb_sp_bram_arb2: table vectors, corner sequences and random traffic against a transaction model
module tb_sp_bram_arb2;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, req_a, we_a, req_b, we_b;
    logic [5:0] addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic gnt_a0, gnt_b0, rvalid_a0, rvalid_b0, mem_we0;
    logic gnt_a1, gnt_b1, rvalid_a1, rvalid_b1, mem_we1;
    logic [5:0] mem_addr0, mem_addr1;
    logic [15:0] mem_din0, mem_din1, mem_dout0, mem_dout1;
    logic [15:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic [15:0] ram0 [64];
    logic [15:0] ram1 [64];

    int n_chk = 0, n_fail = 0;

    sp_bram_arb2 #(.G_ADDR(6), .G_WIDTH(16), .G_RR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a0), .rvalid_a(rvalid_a0), .rdata_a(rdata_a0),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b0), .rvalid_b(rvalid_b0), .rdata_b(rdata_b0),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_din(mem_din0), .mem_dout(mem_dout0)
    );

    sp_bram_arb2 #(.G_ADDR(6), .G_WIDTH(16), .G_RR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a1), .rvalid_a(rvalid_a1), .rdata_a(rdata_a1),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b1), .rvalid_b(rvalid_b1), .rdata_b(rdata_b1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_dout(mem_dout1)
    );

    // no-change single-port RAMs, one per arbiter instance
    always @(posedge clk) begin
        if (mem_we0) ram0[mem_addr0] <= mem_din0;
        else mem_dout0 <= ram0[mem_addr0];
        if (mem_we1) ram1[mem_addr1] <= mem_din1;
        else mem_dout1 <= ram1[mem_addr1];
    end

    // reference model: per instance, memory image, last winner (1=A, 2=B) and pending read
    logic [15:0] rmem [2][64];
    int last_w [2];
    bit pv [2];
    int pp [2];
    logic [15:0] pd [2];

    // sampled outputs of the last step
    logic s_ga, s_gb, s_rva, s_rvb, s_ga0;
    logic [15:0] s_dout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int winner(input int k);
        if (!rst_n) return 0;
        if (req_a && req_b) return (k == 0 || last_w[k] == 2) ? 1 : 2;
        return req_a ? 1 : req_b ? 2 : 0;
    endfunction

    task automatic check_inst(input int k, input logic ga, input logic gb, input logic we,
                              input logic [5:0] ad, input logic [15:0] dn, input logic rva,
                              input logic rvb, input logic [15:0] rda, input logic [15:0] rdb);
        int w = winner(k);
        chk($sformatf("gnt_a[rr=%0d]", k), 32'(ga), 32'(w == 1));
        chk($sformatf("gnt_b[rr=%0d]", k), 32'(gb), 32'(w == 2));
        chk($sformatf("mem_we[rr=%0d]", k), 32'(we), 32'(w == 1 ? we_a : w == 2 ? we_b : 1'b0));
        chk($sformatf("mem_addr[rr=%0d]", k), 32'(ad), 32'(w == 1 ? addr_a : w == 2 ? addr_b : 6'd0));
        chk($sformatf("mem_din[rr=%0d]", k), 32'(dn), 32'(w == 1 ? wdata_a : w == 2 ? wdata_b : 16'd0));
        chk($sformatf("rvalid_a[rr=%0d]", k), 32'(rva), 32'(pv[k] && pp[k] == 1));
        chk($sformatf("rvalid_b[rr=%0d]", k), 32'(rvb), 32'(pv[k] && pp[k] == 2));
        if (pv[k] && pp[k] == 1) chk($sformatf("rdata_a[rr=%0d]", k), 32'(rda), 32'(pd[k]));
        if (pv[k] && pp[k] == 2) chk($sformatf("rdata_b[rr=%0d]", k), 32'(rdb), 32'(pd[k]));
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int w = winner(k);
            logic wr;
            logic [5:0] ad;
            wr = (w == 1) ? we_a : we_b;
            ad = (w == 1) ? addr_a : addr_b;
            pv[k] = (w != 0) && !wr;
            pp[k] = w;
            if (pv[k]) pd[k] = rmem[k][ad];
            if (w != 0 && wr) rmem[k][ad] = (w == 1) ? wdata_a : wdata_b;
            if (w != 0) last_w[k] = w;
        end
    endtask

    task automatic step(input logic ra, input logic wa, input logic [5:0] aa, input logic [15:0] da,
                        input logic rb, input logic wb, input logic [5:0] ab, input logic [15:0] db,
                        input logic rs);
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
        rst_n = rs;
        if (!rs) for (int k = 0; k < 2; k++) begin pv[k] = 1'b0; last_w[k] = 2; end
        #4;
        check_inst(0, gnt_a0, gnt_b0, mem_we0, mem_addr0, mem_din0, rvalid_a0, rvalid_b0, rdata_a0, rdata_b0);
        check_inst(1, gnt_a1, gnt_b1, mem_we1, mem_addr1, mem_din1, rvalid_a1, rvalid_b1, rdata_a1, rdata_b1);
        s_ga = gnt_a1; s_gb = gnt_b1; s_rva = rvalid_a1; s_rvb = rvalid_b1;
        s_dout = mem_dout1; s_ga0 = gnt_a0;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic ra, wa; logic [5:0] aa; logic [15:0] da;
        logic rb, wb; logic [5:0] ab; logic [15:0] db;
        logic ega, egb, erva, ervb, cd; logic [15:0] edout;
    } vec_t;

    vec_t tbl [7];

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram0[i] = 16'hA500 + 16'(i);
            ram1[i] = 16'hA500 + 16'(i);
            rmem[0][i] = 16'hA500 + 16'(i);
            rmem[1][i] = 16'hA500 + 16'(i);
        end
        // expectations below are for the round-robin instance
        tbl[0] = '{1, 1, 6'd5, 16'h1234, 0, 0, 6'd0, 16'h0, 1, 0, 0, 0, 0, 16'h0000};
        tbl[1] = '{1, 0, 6'd5, 16'h0,    0, 0, 6'd0, 16'h0, 1, 0, 0, 0, 1, 16'hA500};
        tbl[2] = '{0, 0, 6'd0, 16'h0,    0, 0, 6'd0, 16'h0, 0, 0, 1, 0, 1, 16'h1234};
        tbl[3] = '{0, 0, 6'd0, 16'h0,    1, 0, 6'd7, 16'h0, 0, 1, 0, 0, 1, 16'hA500};
        tbl[4] = '{1, 1, 6'd3, 16'hBEEF, 1, 0, 6'd3, 16'h0, 1, 0, 0, 1, 1, 16'hA507};
        tbl[5] = '{0, 0, 6'd0, 16'h0,    1, 0, 6'd3, 16'h0, 0, 1, 0, 0, 1, 16'hA507};
        tbl[6] = '{0, 0, 6'd0, 16'h0,    0, 0, 6'd0, 16'h0, 0, 0, 0, 1, 1, 16'hBEEF};

        rst_n = 1'b0;
        req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 2, 0, 0);
        chk("gnt_in_reset", 32'({s_ga, s_gb}), 32'd0);

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].ra, tbl[i].wa, tbl[i].aa, tbl[i].da, tbl[i].rb, tbl[i].wb, tbl[i].ab, tbl[i].db, 1);
            chk($sformatf("tbl%0d.gnt_a", i), 32'(s_ga), 32'(tbl[i].ega));
            chk($sformatf("tbl%0d.gnt_b", i), 32'(s_gb), 32'(tbl[i].egb));
            chk($sformatf("tbl%0d.rvalid_a", i), 32'(s_rva), 32'(tbl[i].erva));
            chk($sformatf("tbl%0d.rvalid_b", i), 32'(s_rvb), 32'(tbl[i].ervb));
            if (tbl[i].cd) chk($sformatf("tbl%0d.mem_dout", i), 32'(s_dout), 32'(tbl[i].edout));
        end

        // both read continuously: round-robin alternates from A, fixed priority always picks A
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 6'(10 + i), 0, 1, 0, 6'(20 + i), 0, 1);
            chk($sformatf("alt_rr%0d", i), 32'(s_ga), 32'(i % 2 == 0));
            chk($sformatf("fixed_a%0d", i), 32'(s_ga0), 32'd1);
        end
        step(0, 0, 0, 0, 1, 0, 6'd20, 0, 1);

        // reset right after a read grant cancels the pending rvalid
        step(1, 0, 6'd5, 0, 0, 0, 0, 0, 1);
        chk("rd_before_rst", 32'(s_ga), 32'd1);
        step(1, 1, 6'd9, 16'h5555, 1, 0, 6'd9, 0, 0);
        chk("rst_no_rvalid", 32'({s_rva, s_rvb}), 32'd0);
        chk("rst_no_gnt", 32'({s_ga, s_gb}), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("post_rst_no_rvalid", 32'(s_rva), 32'd0);
        step(1, 0, 6'd9, 0, 1, 0, 6'd9, 0, 1);
        chk("post_rst_a_first", 32'(s_ga), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 6'd1, 0, 1, 0, 6'd2, 0, 1);
        chk("idle_keeps_last", 32'(s_ga), 32'd0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 39) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
